// File: rtl/booth_pkg.sv
// Shared definitions for the Booth dot-product accumulator: FSM state
// type, default datapath sizes and the counter-width helper.
package booth_pkg;

    // Accumulator FSM: collecting products, or holding a finished result
    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    localparam int DEF_PROD_W = 8;
    localparam int DEF_ACC_W  = 12;
    localparam int DEF_LEN    = 4;

    // Bits needed to count 0..len-1; a single-product dot product still
    // gets a one-bit counter so the vector is never zero-width.
    function automatic int cnt_width(input int len);
        if (len > 1) begin
            return $clog2(len);
        end
        return 1;
    endfunction

endpackage

// File: rtl/booth_sat_add.sv
// Combinational W-bit signed adder with a signed-overflow flag.
// Macro BOOTH_ACC_SATURATE_EN: when defined, an overflowing sum is clamped
// to the signed extreme in the direction of the overflow; otherwise the
// sum wraps modulo 2^W. The overflow flag is reported in both builds.
module booth_sat_add #(
    parameter int W = 12
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         ovf
);

    logic [W-1:0] raw_sum;

    assign raw_sum = a + b;

    // Overflow only when both operands share a sign that the result lost
    assign ovf = (a[W-1] == b[W-1]) && (raw_sum[W-1] != a[W-1]);

`ifdef BOOTH_ACC_SATURATE_EN
    localparam logic [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

    // Clamp toward the operands' common sign when the addition overflows
    always_comb begin
        sum = raw_sum;
        if (ovf) begin
            sum = a[W-1] ? SAT_MIN : SAT_MAX;
        end
    end
`else
    assign sum = raw_sum;
`endif

endmodule

// File: rtl/booth_dot_accumulator.sv
// Dot-product accumulation stage behind the Booth multiplier: sums LEN
// signed products arriving on a valid/ready stream and presents the sum
// plus a sticky overflow flag on a second valid/ready interface.
// Macro BOOTH_ACC_SATURATE_EN selects saturating accumulation (see
// booth_sat_add); the default build wraps.
module booth_dot_accumulator
    import booth_pkg::*;
#(
    parameter int PROD_W = DEF_PROD_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int LEN    = DEF_LEN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_ovf
);

    localparam int CNT_W = cnt_width(LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

    state_t             state_reg,   state_next;
    logic [ACC_W-1:0]   acc_reg,     acc_next;
    logic [CNT_W-1:0]   cnt_reg,     cnt_next;
    logic               sticky_reg,  sticky_next;
    logic [ACC_W-1:0]   out_sum_reg, out_sum_next;
    logic               out_ovf_reg, out_ovf_next;

    logic [ACC_W-1:0]   prod_ext;
    logic [ACC_W-1:0]   add_sum;
    logic               add_ovf;
    logic               accept;
    logic               last_accept;

    // Sign-extend the product into the accumulator width; the upper bits
    // are all copies of the product's sign bit.
    assign prod_ext[PROD_W-1:0] = in_prod;
    generate
        for (genvar gi = PROD_W; gi < ACC_W; gi++) begin : g_sext
            assign prod_ext[gi] = in_prod[PROD_W-1];
        end
    endgenerate

    booth_sat_add #(
        .W (ACC_W)
    ) u_add (
        .a   (acc_reg),
        .b   (prod_ext),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    // Handshake flags come straight from the registered state so neither
    // depends combinationally on in_valid or out_ready.
    assign in_ready    = (state_reg == ACCUM);
    assign out_valid   = (state_reg == DONE);
    assign out_sum     = out_sum_reg;
    assign out_ovf     = out_ovf_reg;

    assign accept      = in_valid && in_ready;
    assign last_accept = accept && (cnt_reg == CNT_LAST);

    // Next-state decode: clear wins, then accumulate or release the result
    always_comb begin
        state_next   = state_reg;
        acc_next     = acc_reg;
        cnt_next     = cnt_reg;
        sticky_next  = sticky_reg;
        out_sum_next = out_sum_reg;
        out_ovf_next = out_ovf_reg;

        if (clr) begin
            state_next  = ACCUM;
            acc_next    = '0;
            cnt_next    = '0;
            sticky_next = 1'b0;
        end else begin
            case (state_reg)
                ACCUM: begin
                    if (last_accept) begin
                        // Final product: publish the sum and start afresh
                        out_sum_next = add_sum;
                        out_ovf_next = sticky_reg | add_ovf;
                        state_next   = DONE;
                        acc_next     = '0;
                        cnt_next     = '0;
                        sticky_next  = 1'b0;
                    end else if (accept) begin
                        acc_next    = add_sum;
                        cnt_next    = cnt_reg + 1'b1;
                        sticky_next = sticky_reg | add_ovf;
                    end
                end
                DONE: begin
                    // Result stays put until the consumer takes it
                    if (out_ready) begin
                        state_next = ACCUM;
                    end
                end
                default: begin
                    state_next = ACCUM;
                end
            endcase
        end
    end

    // State and datapath registers; reset drops everything immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ACCUM;
            acc_reg     <= '0;
            cnt_reg     <= '0;
            sticky_reg  <= 1'b0;
            out_sum_reg <= '0;
            out_ovf_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            acc_reg     <= acc_next;
            cnt_reg     <= cnt_next;
            sticky_reg  <= sticky_next;
            out_sum_reg <= out_sum_next;
            out_ovf_reg <= out_ovf_next;
        end
    end

endmodule

// File: tb/tb_booth_dot_accumulator.sv
// Scoreboard bench for booth_dot_accumulator. Three instances cover the
// default sizing, an 8-bit accumulator that overflows (LEN=2) and LEN=1.
// The driver pushes expected results from an integer model; a separate
// monitor compares every presented result and the handshake flags.
module tb_booth_dot_accumulator;

    localparam int NI = 3;

    typedef struct {
        int sum;
        bit ovf;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n     [NI];
    logic       clr       [NI];
    logic       in_valid  [NI];
    logic       in_ready  [NI];
    logic [7:0] in_prod   [NI];
    logic       out_valid [NI];
    logic       out_ready [NI];
    logic       out_ovf   [NI];
    logic [11:0] sum_a;
    logic [7:0]  sum_b;
    logic [7:0]  sum_c;

    booth_dot_accumulator #(.PROD_W(8), .ACC_W(12), .LEN(4)) dut_a (
        .clk(clk), .rst_n(rst_n[0]), .clr(clr[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_prod(in_prod[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_sum(sum_a), .out_ovf(out_ovf[0])
    );

    booth_dot_accumulator #(.PROD_W(8), .ACC_W(8), .LEN(2)) dut_b (
        .clk(clk), .rst_n(rst_n[1]), .clr(clr[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_prod(in_prod[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_sum(sum_b), .out_ovf(out_ovf[1])
    );

    booth_dot_accumulator #(.PROD_W(8), .ACC_W(8), .LEN(1)) dut_c (
        .clk(clk), .rst_n(rst_n[2]), .clr(clr[2]),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_prod(in_prod[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_sum(sum_c), .out_ovf(out_ovf[2])
    );

    // ---------------- shared bookkeeping ----------------
    int   n_checks = 0;
    int   n_fail   = 0;
    int   tmo_count = 0;
    bit   rnd_ready = 1'b0;
    bit   end_req = 1'b0;
    bit   end_ack = 1'b0;

    res_t q0[$];
    res_t q1[$];
    res_t q2[$];

    function automatic int accw_of(int i);
        return (i == 0) ? 12 : 8;
    endfunction

    function automatic int len_of(int i);
        case (i)
            0:       return 4;
            1:       return 2;
            default: return 1;
        endcase
    endfunction

    function automatic int sum_of(int i);
        case (i)
            0:       return int'($signed(sum_a));
            1:       return int'($signed(sum_b));
            default: return int'($signed(sum_c));
        endcase
    endfunction

    function automatic void q_push(int i, res_t r);
        case (i)
            0:       q0.push_back(r);
            1:       q1.push_back(r);
            default: q2.push_back(r);
        endcase
    endfunction

    function automatic int q_size(int i);
        case (i)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic res_t q_front(int i);
        case (i)
            0:       return q0[0];
            1:       return q1[0];
            default: return q2[0];
        endcase
    endfunction

    function automatic void q_pop(int i);
        res_t r;
        case (i)
            0:       r = q0.pop_front();
            1:       r = q1.pop_front();
            default: r = q2.pop_front();
        endcase
    endfunction

    // ---------------- reference model ----------------
    int m_acc [NI];
    int m_cnt [NI];
    bit m_ovf [NI];

    function automatic void model_clear(int i);
        m_acc[i] = 0;
        m_cnt[i] = 0;
        m_ovf[i] = 1'b0;
    endfunction

    // Plain integer arithmetic: add, detect leaving the signed range,
    // then wrap or clamp back into it.
    function automatic void model_accept(int i, int p);
        int   w;
        int   hi;
        int   lo;
        int   s;
        res_t r;
        w  = accw_of(i);
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
        s  = m_acc[i] + p;
        if (s > hi || s < lo) begin
            m_ovf[i] = 1'b1;
`ifdef BOOTH_ACC_SATURATE_EN
            s = (s > hi) ? hi : lo;
`else
            s = (s > hi) ? s - (1 << w) : s + (1 << w);
`endif
        end
        m_acc[i] = s;
        m_cnt[i] = m_cnt[i] + 1;
        if (m_cnt[i] == len_of(i)) begin
            r.sum = s;
            r.ovf = m_ovf[i];
            q_push(i, r);
            model_clear(i);
        end
    endfunction

    // ---------------- driver tasks (entered at posedge + 1) ----------------
    task automatic send(int i, int p);
        int waits;
        bit ok;
        waits = 0;
        ok    = 1'b0;
        in_valid[i] = 1'b1;
        in_prod[i]  = 8'(p);
        while (!ok && waits < 40) begin
            @(negedge clk);
            if (in_ready[i]) begin
                ok = 1'b1;
            end else begin
                waits++;
                @(posedge clk);
                #1;
                out_ready[i] = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
            end
        end
        if (ok) begin
            @(posedge clk);
            model_accept(i, p);
            #1;
        end else begin
            tmo_count++;
        end
        in_valid[i] = 1'b0;
    endtask

    task automatic idle(int i, int n);
        in_valid[i] = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clr_pulse(int i, bit with_prod, int p);
        clr[i]      = 1'b1;
        in_valid[i] = with_prod;
        in_prod[i]  = 8'(p);
        @(posedge clk);
        model_clear(i);
        #1;
        clr[i]      = 1'b0;
        in_valid[i] = 1'b0;
    endtask

    // Reset is asserted and released between clock edges
    task automatic async_reset(int i);
        #3;
        rst_n[i] = 1'b0;
        model_clear(i);
        @(negedge clk);
        #2;
        rst_n[i] = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic random_run(int i, int n);
        int r;
        rnd_ready = 1'b1;
        for (int k = 0; k < n; k++) begin
            out_ready[i] = ($urandom_range(0, 3) != 0);
            r = int'($urandom_range(0, 31));
            if (r == 0) begin
                clr_pulse(i, $urandom_range(0, 1) == 1, int'($urandom_range(0, 255)) - 128);
            end else if (r < 6) begin
                idle(i, int'($urandom_range(1, 3)));
            end
            send(i, int'($urandom_range(0, 255)) - 128);
        end
        rnd_ready    = 1'b0;
        out_ready[i] = 1'b1;
        idle(i, 4);
    endtask

    // ---------------- monitor ----------------
    bit exp_done [NI];
    int mon_cnt  [NI];

    function automatic void chk(int i, string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s inst%0d: got %0d, expected %0d (t=%0t)", name, i, act, exp, $time);
        end
    endfunction

    function automatic void mon_step(int i);
        res_t r;
        if (!rst_n[i]) begin
            chk(i, "reset_in_ready", int'(in_ready[i]), 1);
            chk(i, "reset_out_valid", int'(out_valid[i]), 0);
            chk(i, "reset_out_sum", sum_of(i), 0);
            chk(i, "reset_out_ovf", int'(out_ovf[i]), 0);
            exp_done[i] = 1'b0;
            mon_cnt[i]  = 0;
        end else begin
            chk(i, "in_ready", int'(in_ready[i]), int'(!exp_done[i]));
            chk(i, "out_valid", int'(out_valid[i]), int'(exp_done[i]));
            if (out_valid[i]) begin
                if (q_size(i) == 0) begin
                    chk(i, "unexpected_result_pending", 0, 1);
                end else begin
                    r = q_front(i);
                    chk(i, "out_sum", sum_of(i), r.sum);
                    chk(i, "out_ovf", int'(out_ovf[i]), int'(r.ovf));
                    if (out_ready[i] || clr[i]) begin
                        q_pop(i);
                        $display("result inst%0d: sum=%0d ovf=%0d", i, sum_of(i), out_ovf[i]);
                    end
                end
            end
            if (clr[i]) begin
                exp_done[i] = 1'b0;
                mon_cnt[i]  = 0;
            end else if (!exp_done[i]) begin
                if (in_valid[i]) begin
                    mon_cnt[i] = mon_cnt[i] + 1;
                    if (mon_cnt[i] == len_of(i)) begin
                        exp_done[i] = 1'b1;
                        mon_cnt[i]  = 0;
                    end
                end
            end else if (out_ready[i]) begin
                exp_done[i] = 1'b0;
            end
        end
    endfunction

    initial begin
        for (int i = 0; i < NI; i++) begin
            exp_done[i] = 1'b0;
            mon_cnt[i]  = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                mon_step(i);
            end
            if (end_req && !end_ack) begin
                for (int i = 0; i < NI; i++) begin
                    chk(i, "results_outstanding", q_size(i), 0);
                end
                chk(0, "handshake_timeouts", tmo_count, 0);
                end_ack = 1'b1;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < NI; i++) begin
            rst_n[i]     = 1'b0;
            clr[i]       = 1'b0;
            in_valid[i]  = 1'b0;
            in_prod[i]   = 8'd0;
            out_ready[i] = 1'b1;
            model_clear(i);
        end
        repeat (3) @(negedge clk);
        #2;
        for (int i = 0; i < NI; i++) rst_n[i] = 1'b1;
        @(posedge clk);
        #1;

        // Basic sum: -6
        send(0, 10); send(0, -3); send(0, 7); send(0, -20);
        idle(0, 2);

        // Bubbles between products and a held-off consumer: 10
        out_ready[0] = 1'b0;
        send(0, 1); idle(0, 1);
        send(0, 2); idle(0, 1);
        send(0, 3); idle(0, 1);
        send(0, 4);
        idle(0, 5);
        out_ready[0] = 1'b1;
        idle(0, 2);

        // Clear discards 50, 60 and the simultaneous 70: 4
        send(0, 50); send(0, 60);
        clr_pulse(0, 1'b1, 70);
        send(0, 1); send(0, 1); send(0, 1); send(0, 1);
        idle(0, 2);

        // Asynchronous reset mid-dot-product, then -20
        send(0, 9); send(0, 9);
        async_reset(0);
        send(0, -5); send(0, -5); send(0, -5); send(0, -5);
        idle(0, 2);

        // 8-bit accumulator overflow in both directions
        send(1, 127); send(1, 127);
        send(1, -128); send(1, -128);
        send(1, -100); send(1, -20);
        idle(1, 2);

        // LEN=1 back-to-back results
        send(2, 3); send(2, -4);
        idle(2, 2);

        random_run(0, 150);
        random_run(1, 150);
        random_run(2, 100);

        end_req = 1'b1;
        repeat (3) @(posedge clk);
        if (!end_ack) begin
            $display("FAIL end_check: monitor did not acknowledge");
            $fatal(1, "end check not reached");
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/booth_dot_accumulator.md
# booth_dot_accumulator

Sequential accumulation stage directly downstream of the Booth multiplier. It consumes a stream of signed 8-bit products over a valid/ready handshake and sums a fixed number of them (one dot product) into a wider signed accumulator. It then presents the result, with an overflow flag, on a second valid/ready interface. It turns the combinational multiplier into the datapath of a small MAC / dot-product engine.

## Interface
- PROD_W, 8: width of the signed two's-complement product input.
- ACC_W, 12: width of the signed accumulator and result.
- LEN, 4: number of products per dot product; legal range 1..255.
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous clear; discards the partial sum and any pending result.
- in_valid  input  1  in_prod holds a product.
- in_ready  output  1  block accepts a product this cycle.
- in_prod  input  PROD_W  signed product from the multiplier.
- out_valid  output  1  out_sum and out_ovf hold a finished result.
- out_ready  input  1  consumer takes the result.
- out_sum  output  ACC_W  signed dot-product result.
- out_ovf  output  1  at least one accumulation step overflowed ACC_W.

## Operation
- FSM states:
  - ACCUM: in_ready=1, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Accept means in_valid && in_ready. On each accept:
  - acc <= acc + sign_extend(in_prod).
  - cnt increments.
  - ovf_sticky is ORed with the signed-overflow result of that addition.
- On the LEN-th accept (cnt==LEN-1):
  - out_sum and out_ovf load the final sum and final sticky flag.
  - State goes to DONE; acc, cnt and ovf_sticky clear.
- In DONE, out_valid && out_ready returns the state to ACCUM.
  - out_sum and out_ovf hold their last values; only out_valid drops.
- In DONE, in_valid is ignored and no product is consumed.
- clr has priority over every other event. Next state is ACCUM with acc=0, cnt=0, sticky=0 and out_valid=0.
  - A clr in the same cycle as an accept discards that product.
  - A clr in the same cycle as an output handshake still counts as a clear; the result is considered consumed.
- Arithmetic:
  - in_prod is sign-extended to ACC_W.
  - Overflow occurs when both operands have the same sign and the sum's sign differs from it.
  - No overflow is possible when ACC_W >= PROD_W + ceil(log2(LEN)).
- LEN=1: every accept goes straight to DONE.

## Timing
- Reset (rst_n low, asynchronous): state=ACCUM, acc=0, cnt=0, sticky=0, out_sum=0, out_ovf=0, out_valid=0, in_ready=1.
- Reset asserted mid-dot-product drops all partial state immediately.
- in_ready and out_valid are decoded from registered state only; there is no combinational path from in_valid or out_ready.
- Latency: out_valid rises the cycle after the LEN-th accept.
- Throughput: LEN+1 cycles per result minimum, i.e. LEN accept cycles plus one DONE cycle with out_ready=1.
- Bubbles (in_valid low) do not advance cnt.
- out_sum and out_ovf are stable while out_valid=1 and out_ready=0, however long that lasts.

## Configuration
- BOOTH_ACC_SATURATE_EN defined:
  - An overflowing addition clamps acc to the signed extreme, +(2^(ACC_W-1)-1) or -2^(ACC_W-1), in the direction of the overflow.
  - Later additions start from the clamped value.
  - out_ovf still reports the event.
- Undefined: the addition wraps modulo 2^ACC_W; out_ovf reports the wrap.

## Structure
- Shared package booth_pkg holds:
  - the state typedef (ACCUM, DONE);
  - default PROD_W, ACC_W and LEN constants;
  - a function computing the counter width from LEN.
- One sub-module, booth_sat_add: a combinational ACC_W-bit signed adder with an overflow output.
  - Its saturating behaviour is selected by BOOTH_ACC_SATURATE_EN.
  - The accumulator FSM, counter and registers stay in booth_dot_accumulator.

## Test plan
- Basic sum (defaults): accept 10, -3, 7, -20 back-to-back -> one cycle later out_valid=1, out_sum=-6 (0xFFA), out_ovf=0; in_ready=0 until the handshake.
- Backpressure and bubbles: products 1, 2, 3, 4 with in_valid low every other cycle, out_ready held low 5 cycles -> out_sum=10 stable and in_ready=0 throughout; ACCUM resumes the cycle after out_ready rises.
- Overflow (ACC_W=8, LEN=2): products 127, 127.
  - Macro undefined -> out_sum=-2 (0xFE), out_ovf=1.
  - Macro defined -> out_sum=127 (0x7F), out_ovf=1.
- clr mid-operation: accept 50, 60; pulse clr together with a third product 70; then accept 1, 1, 1, 1 -> out_sum=4, out_ovf=0.
- Asynchronous reset: assert rst_n low between clock edges after two accepts -> in_ready=1, out_valid=0, out_sum=0 immediately; the next four products -5 each -> out_sum=-20.
- LEN=1: stream 3 then -4 with out_ready=1 -> results 3 then -4, one result every 2 cycles.
